// File: rtl/shift_load_register.sv
// N-bit operand register with parallel load, serial shifts and a shift counter that pulses done.
// Optional SHIFT_LOAD_REGISTER_ROTATE_EN: op=11 rotates right instead of arithmetic shift right.
module shift_load_register #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [N-1:0]     in,
  input  logic             shift_en,
  input  logic [1:0]       op,
  input  logic             sin,
  output logic [N-1:0]     out,
  output logic             sout,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(N);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [N-1:0]     r_out;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  logic [N-1:0]     w_shifted;
  logic             w_step;

  always_comb begin
    w_shifted = r_out;
    unique case (op)
      2'b00: w_shifted = r_out;
      2'b01: w_shifted = {r_out[N-2:0], sin};
      2'b10: w_shifted = {sin, r_out[N-1:1]};
`ifdef SHIFT_LOAD_REGISTER_ROTATE_EN
      2'b11: w_shifted = {r_out[0], r_out[N-1:1]};
`else
      2'b11: w_shifted = {r_out[N-1], r_out[N-1:1]};
`endif
      default: w_shifted = r_out;
    endcase
  end

  // An exhausted counter freezes the register: no wrap, no extra done.
  assign w_step = shift_en && (r_count != '0);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_out   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_out   <= in;
      r_count <= CntFull;
      r_done  <= 1'b0;
    end else if (w_step) begin
      r_out   <= w_shifted;
      r_count <= r_count - CntOne;
      r_done  <= (r_count == CntOne);
    end else begin
      r_done  <= 1'b0;
    end
  end

  assign out   = r_out;
  assign count = r_count;
  assign done  = r_done;
  assign busy  = (r_count != '0);
  assign sout  = (op == 2'b01) ? r_out[N-1] : r_out[0];

endmodule

// File: tb/tb_shift_load_register.sv
// Directed table-driven bench for shift_load_register (N=8) plus async-clear sequences.
module tb_shift_load_register;

  logic       clk;
  logic       clear;
  logic       load;
  logic [7:0] in;
  logic       shift_en;
  logic [1:0] op;
  logic       sin;
  logic [7:0] out;
  logic       sout;
  logic [3:0] count;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  shift_load_register #(.N(8)) dut (
    .clk      (clk),
    .clear    (clear),
    .load     (load),
    .in       (in),
    .shift_en (shift_en),
    .op       (op),
    .sin      (sin),
    .out      (out),
    .sout     (sout),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] din;
    logic       sh;
    logic [1:0] op;
    logic       sin;
    logic [7:0] eout;
    logic [3:0] ecnt;
    logic       edone;
    logic       esout;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic ld, input logic [7:0] din, input logic sh,
                         input logic [1:0] o, input logic s, input logic [7:0] eout,
                         input logic [3:0] ecnt, input logic edone, input logic esout);
    vec_t v;
    v.ld = ld; v.din = din; v.sh = sh; v.op = o; v.sin = s;
    v.eout = eout; v.ecnt = ecnt; v.edone = edone; v.esout = esout;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_rot;
  logic       watch_done;
  logic       saw_done;

  initial begin
    clear = 1'b1; load = 1'b0; in = '0; shift_en = 1'b0; op = 2'b00; sin = 1'b0;
    watch_done = 1'b0; saw_done = 1'b0;
    #3;
    check("reset_out", 32'(out), 32'h00);
    check("reset_count", 32'(count), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sout", 32'(sout), 32'd0);
    @(negedge clk);
    clear = 1'b0;

    // Async clear between edges
    load = 1'b1; in = 8'hA5;
    @(posedge clk); #1;
    load = 1'b0;
    check("async_pre_out", 32'(out), 32'hA5);
    #2 clear = 1'b1;
    #1;
    check("async_out", 32'(out), 32'h00);
    check("async_count", 32'(count), 32'd0);
    @(negedge clk);
    clear = 1'b0;

`ifdef SHIFT_LOAD_REGISTER_ROTATE_EN
    exp_rot = 8'h80;
`else
    exp_rot = 8'h00;
`endif
    // Full shl sequence from B5
    add_vec(1, 8'hB5, 1, 2'b01, 0, 8'hB5, 4'd8, 0, 1);
    add_vec(0, 8'h00, 1, 2'b01, 0, 8'h6A, 4'd7, 0, 0);
    add_vec(0, 8'h00, 1, 2'b01, 0, 8'hD4, 4'd6, 0, 1);
    add_vec(0, 8'h00, 1, 2'b01, 0, 8'hA8, 4'd5, 0, 1);
    add_vec(0, 8'h00, 1, 2'b01, 0, 8'h50, 4'd4, 0, 0);
    add_vec(0, 8'h00, 1, 2'b01, 0, 8'hA0, 4'd3, 0, 1);
    add_vec(0, 8'h00, 1, 2'b01, 0, 8'h40, 4'd2, 0, 0);
    add_vec(0, 8'h00, 1, 2'b01, 0, 8'h80, 4'd1, 0, 1);
    add_vec(0, 8'h00, 1, 2'b01, 0, 8'h00, 4'd0, 1, 0);
    // Exhausted counter: shifts ignored, no done
    add_vec(0, 8'h00, 1, 2'b10, 1, 8'h00, 4'd0, 0, 0);
    add_vec(0, 8'h00, 1, 2'b10, 1, 8'h00, 4'd0, 0, 0);
    add_vec(0, 8'h00, 1, 2'b10, 1, 8'h00, 4'd0, 0, 0);
    // Load wins over simultaneous shift
    add_vec(1, 8'h0F, 1, 2'b01, 0, 8'h0F, 4'd8, 0, 0);
    // Idle step decrements without moving data; shr fills MSB from sin
    add_vec(0, 8'h00, 1, 2'b00, 1, 8'h0F, 4'd7, 0, 1);
    add_vec(0, 8'h00, 1, 2'b10, 1, 8'h87, 4'd6, 0, 1);
    add_vec(0, 8'h00, 0, 2'b10, 0, 8'h87, 4'd6, 0, 1);
    // op=11 on 81 and 01
    add_vec(1, 8'h81, 0, 2'b00, 0, 8'h81, 4'd8, 0, 1);
    add_vec(0, 8'h00, 1, 2'b11, 1, 8'hC0, 4'd7, 0, 0);
    add_vec(1, 8'h01, 0, 2'b00, 0, 8'h01, 4'd8, 0, 1);
    add_vec(0, 8'h00, 1, 2'b11, 1, exp_rot, 4'd7, 0, exp_rot[0]);

    for (int i = 0; i < vecs.size(); i++) begin
      load = vecs[i].ld; in = vecs[i].din; shift_en = vecs[i].sh;
      op = vecs[i].op; sin = vecs[i].sin;
      @(posedge clk); #1;
      check($sformatf("v%0d_out", i), 32'(out), 32'(vecs[i].eout));
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].edone));
      check($sformatf("v%0d_sout", i), 32'(sout), 32'(vecs[i].esout));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].ecnt != 0));
    end

    // Load FF, 4 shifts, then abort with clear
    load = 1'b1; in = 8'hFF; shift_en = 1'b0; op = 2'b10; sin = 1'b0;
    @(posedge clk); #1;
    load = 1'b0; shift_en = 1'b1; watch_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    check("abort_pre_out", 32'(out), 32'h0F);
    check("abort_pre_count", 32'(count), 32'd4);
    #2 clear = 1'b1;
    #1;
    check("abort_out", 32'(out), 32'h00);
    check("abort_count", 32'(count), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
    end
    watch_done = 1'b0;
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_final_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  always @(posedge clk) begin
    #1;
    if (watch_done && done) saw_done = 1'b1;
  end

endmodule
